// File: rtl/cpu4_mem_pkg.sv
// Shared constants and state encoding for the cpu4 memory-side controllers.
package cpu4_mem_pkg;

  localparam int unsigned CPU4_ADDR_W           = 8;
  localparam int unsigned CPU4_DATA_W           = 8;
  localparam int unsigned CPU4_READ_LATENCY_MAX = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD_ADDR = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/cpu4_ram_master.sv
// Single-outstanding load/store controller in front of the cpu4_ram synchronous RAM.
// Optional write-verify readback: define CPU4_RAM_MASTER_WVERIFY_EN.
module cpu4_ram_master
  import cpu4_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = CPU4_ADDR_W,
  parameter int unsigned DATA_W       = CPU4_DATA_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wen_q, ram_wen_d;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
  logic              we_q, we_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  // RAM pins are loaded from the next-state decision so they are valid
  // in the same cycle the FSM enters WR / RD_ADDR.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wen_d     = 1'b0;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
    we_d          = we_q;
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          ram_address_d = req_addr;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
          we_d          = req_we;
`endif
          if (req_we) begin
            ram_data_d = req_wdata;
            ram_wen_d  = 1'b1;
            state_d    = ST_WR;
          end else begin
            state_d    = ST_RD_ADDR;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WR: begin
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
        state_d     = ST_RD_ADDR;
`else
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
`endif
      end
      ST_RD_ADDR: begin
        cnt_d   = WAIT_LOAD;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_rdata_d = ram_q;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
          // ram_data_q still holds the stored byte during the readback.
          rsp_err_d   = we_q && (ram_q != ram_data_q);
`endif
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wen_q     <= 1'b0;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
      we_q          <= 1'b0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wen_q     <= ram_wen_d;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
      we_q          <= we_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wen     = ram_wen_q;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu4_ram_master.sv
// Bench for cpu4_ram_master: behavioural RAM, transaction-level reference model, random traffic.
module tb_cpu4_ram_master;

  localparam int RL = 1;
`ifdef CPU4_RAM_MASTER_WVERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, ram_wen;
  logic [7:0] rsp_rdata, ram_address, ram_data, ram_q;

  always #10 clk = ~clk;

  cpu4_ram_master #(
    .ADDR_W(8),
    .DATA_W(8),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_wen(ram_wen),
    .ram_q(ram_q)
  );

  // cpu4_ram stand-in: write on wen, q valid RL cycles after the address edge
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] q_pipe  [RL]  = '{default: 8'h00};
  bit         force_q_zero = 1'b0;

  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_address] <= ram_data;
    q_pipe[0] <= ram_mem[ram_address];
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_q = force_q_zero ? 8'h00 : q_pipe[RL-1];

  // reference model: transaction timing relative to the accept cycle
  int         cyc = 0;
  int         ready_from = 1 << 30;
  bit         have_rsp = 0, have_wen = 0, have_rda = 0;
  int         rsp_cyc, wen_cyc, rda_cyc;
  logic [7:0] exp_addr, exp_wdata, exp_rdata;
  bit         exp_err, exp_chk_data;
  logic [7:0] model_mem [256] = '{default: 8'h00};

  int         n_tests = 0, n_fail = 0;
  int         rsp_seen = 0;
  logic [7:0] last_rdata;
  bit         last_err;
  bit         last_fire;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return cyc >= ready_from;
  endfunction

  task automatic accept(input bit we, input logic [7:0] a, input logic [7:0] d);
    exp_addr  = a;
    exp_wdata = d;
    have_rsp  = 1'b1;
    if (we) begin
      model_mem[a] = d;
      have_wen = 1'b1;
      wen_cyc  = cyc + 1;
      if (VERIFY) begin
        have_rda     = 1'b1;
        rda_cyc      = cyc + 2;
        rsp_cyc      = cyc + 3 + RL;
        exp_chk_data = 1'b1;
        exp_rdata    = force_q_zero ? 8'h00 : d;
        exp_err      = (exp_rdata != d);
      end else begin
        rsp_cyc      = cyc + 2;
        exp_chk_data = 1'b0;
        exp_err      = 1'b0;
      end
    end else begin
      have_rda     = 1'b1;
      rda_cyc      = cyc + 1;
      rsp_cyc      = cyc + 2 + RL;
      exp_chk_data = 1'b1;
      exp_rdata    = force_q_zero ? 8'h00 : model_mem[a];
      exp_err      = 1'b0;
    end
    ready_from = rsp_cyc + 1;
  endtask

  task automatic tick();
    bit rst_now, fire;
    rst_now = !resetn;
    fire    = !rst_now && req_valid && model_ready();
    if (fire) accept(req_we, req_addr, req_wdata);
    @(posedge clk);
    #1;
    cyc++;
    last_fire = fire;
    if (rst_now) begin
      have_rsp   = 1'b0;
      have_wen   = 1'b0;
      have_rda   = 1'b0;
      ready_from = cyc + 1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_ram_wen", ram_wen, 0);
      check("rst_ram_address", ram_address, 0);
      check("rst_ram_data", ram_data, 0);
    end else begin
      check("req_ready", req_ready, model_ready());
      check("rsp_valid", rsp_valid, have_rsp && cyc == rsp_cyc);
      check("ram_wen", ram_wen, have_wen && cyc == wen_cyc);
      if (have_wen && cyc == wen_cyc) begin
        check("wr_address", ram_address, exp_addr);
        check("wr_data", ram_data, exp_wdata);
        have_wen = 1'b0;
      end
      if (have_rda && cyc == rda_cyc) begin
        check("rd_address", ram_address, exp_addr);
        have_rda = 1'b0;
      end
      if (have_rsp && cyc == rsp_cyc) begin
        if (exp_chk_data) check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        have_rsp = 1'b0;
      end
    end
    if (rsp_valid) begin
      rsp_seen++;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end
  endtask

  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d, input bit hold);
    bit got;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = last_fire;
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int start;
    start = rsp_seen;
    for (int i = 0; i < 20 && rsp_seen == start; i++) tick();
    check(tag, rsp_seen - start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [7:0] a, d;

    // reset for two edges, then release
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check("ready_after_reset", req_ready, 1);

    // store then load
    issue(1'b1, 8'h00, 8'hAA, 1'b0);
    wait_rsp("store_rsp");
    issue(1'b0, 8'h00, 8'h00, 1'b0);
    wait_rsp("load_rsp");
    check("load_00_data", last_rdata, 8'hAA);
    check("load_00_err", last_err, 0);

    // address boundary
    issue(1'b1, 8'hFF, 8'h55, 1'b0);
    wait_rsp("store_ff_rsp");
    issue(1'b1, 8'h00, 8'h33, 1'b0);
    wait_rsp("store_00_rsp");
    issue(1'b0, 8'hFF, 8'h00, 1'b0);
    wait_rsp("load_ff_rsp");
    check("load_ff_data", last_rdata, 8'h55);

    // back-to-back loads with req_valid held
    for (int i = 1; i <= 3; i++) begin
      issue(1'b1, 8'(i), 8'(8'h10 * i + 1), 1'b0);
      wait_rsp("b2b_prep_rsp");
    end
    start = rsp_seen;
    issue(1'b0, 8'h01, 8'h00, 1'b1);
    issue(1'b0, 8'h02, 8'h00, 1'b1);
    issue(1'b0, 8'h03, 8'h00, 1'b0);
    for (int i = 0; i < 20 && rsp_seen - start < 3; i++) tick();
    repeat (3) tick();
    check("b2b_rsp_count", rsp_seen - start, 3);
    check("b2b_last_data", last_rdata, 8'h31);

    // reset while waiting on read data
    issue(1'b0, 8'hFF, 8'h00, 1'b0);
    tick();
    start = rsp_seen;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    repeat (RL + 3) tick();
    check("mid_reset_no_rsp", rsp_seen - start, 0);
    check("mid_reset_ready", req_ready, 1);
    issue(1'b0, 8'hFF, 8'h00, 1'b0);
    wait_rsp("post_reset_load_rsp");
    check("post_reset_load_data", last_rdata, 8'h55);

`ifdef CPU4_RAM_MASTER_WVERIFY_EN
    issue(1'b1, 8'h10, 8'h5A, 1'b0);
    wait_rsp("verify_rsp");
    check("verify_rdata", last_rdata, 8'h5A);
    check("verify_err", last_err, 0);
    force_q_zero = 1'b1;
    issue(1'b1, 8'h11, 8'hA5, 1'b0);
    wait_rsp("verify_bad_rsp");
    check("verify_bad_err", last_err, 1);
    force_q_zero = 1'b0;
`endif

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
      end else begin
        if (!req_valid && $urandom_range(0, 2) != 0) begin
          a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
          d = 8'($urandom_range(0, 255));
          req_valid = 1'b1;
          req_we    = 1'($urandom_range(0, 1));
          req_addr  = a;
          req_wdata = d;
        end
        tick();
        if (last_fire) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (RL + 6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
